cs_decoder: RTL and testbench
=============================

# cs_decoder

Erasure decoder for the systematic (M, K) cyclic-shift + XOR MDS code produced by `cs_encoder`. It accepts one K-symbol codeword plus a per-symbol erasure mask and recovers the M data symbols. A single erased data symbol is rebuilt from parity 0 with a serial, one-symbol-per-cycle accumulator, followed by an inverse cyclic shift. It sits on the receive side after the symbol de-framer and hands recovered data to the sink over a valid/ready handshake.

## Interface
- M, 2, number of data symbols.
- K, 3, total coded symbols; K > M required.
- WIDTH, 4, bits per symbol.
- SHIFT_TABLE, all 0, `logic [3:0] [K-M][M]`. Same table as the encoder; entry[p][d] is the left-rotate amount of data d into parity p; taken modulo WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid_in  in  1  codeword present.
- ready_in  out  1  decoder can accept; equals (state==IDLE) && rst_n.
- coded_in  in  WIDTH x K  symbols; [0..M-1] data, [M..K-1] parity.
- erasure_in  in  K  bit i=1: coded_in[i] is lost/invalid.
- valid_out  out  1  result valid, held until accepted.
- ready_out  in  1  sink accepts result.
- data_out  out  WIDTH x M  recovered data symbols.
- fail_out  out  1  codeword not recoverable by this block.
- check_err_out  out  1  syndrome mismatch (only with CS_DEC_CHECK_EN; tied 0 otherwise).

## Operation
- FSM states: IDLE, ACCUM, SOLVE, OUT.
- IDLE: on valid_in && ready_in, register coded_in and erasure_in, count data erasures n_e over bits [0..M-1], locate erased index e.
  - n_e==1 and erasure_in[M]==0: load acc <= coded_in[M], idx <= 0, go to ACCUM.
  - n_e==0 (and check disabled, or parity 0 erased): data_out <= data symbols, fail=0, go to OUT.
  - n_e>=2, or n_e==1 with parity 0 erased: data_out <= data with erased positions forced to 0, fail=1, go to OUT.
- ACCUM: one cycle per idx 0..M-1; if idx != e, acc <= acc ^ rotl(data[idx], SHIFT_TABLE[0][idx] % WIDTH); the erased index contributes nothing. Leave when idx==M-1.
- SOLVE: data_out[e] <= rotr(acc, SHIFT_TABLE[0][e] % WIDTH); the other outputs take the captured data; fail=0; go to OUT.
- OUT: valid_out=1. When ready_out=1, clear valid_out and go to IDLE.
- Erasures of parity symbols 1..K-M-1 are ignored; those symbols are never used.
- All rotations are WIDTH-bit cyclic; a shift of 0 is identity.

## Timing
- Reset (rst_n low at a clock edge): state=IDLE, valid_out=0, data_out=0, fail_out=0, check_err_out=0, acc=0, idx=0. This applies from any state; an in-flight codeword is dropped.
- Bypass/fail path: valid_out rises on the 1st edge after acceptance.
- Recovery path: M ACCUM cycles + 1 SOLVE cycle, so valid_out rises on edge M+2 after acceptance (4 for M=2).
- ready_in=0 in all states except IDLE. There is no accept in the same cycle as an OUT handoff. The next accept is possible the cycle after OUT exits.
- Under backpressure (ready_out=0), data_out, fail_out and check_err_out hold stable.
- valid_in and coded_in are ignored while ready_in=0.

## Configuration
- CS_DEC_CHECK_EN defined: with n_e==0 and parity 0 present, the codeword also goes through ACCUM/SOLVE with e=none. The block sets check_err_out = (acc != 0), passes data through unchanged, and keeps fail=0. Latency is M+2.
- CS_DEC_CHECK_EN undefined: check_err_out is constant 0, and n_e==0 always takes the 1-cycle bypass.

## Test plan
All cases use M=2, K=3, WIDTH=4, SHIFT_TABLE[0]={0,1}, and the codeword {4'hA, 4'h3, 4'hC}.
- Erase d0 (erasure_in=3'b001): acc = C^rotl(3,1) = A, so data_out={A,3}, fail=0, valid_out 4 cycles after accept.
- Erase d1 (erasure_in=3'b010): acc = C^A = 6, rotr(6,1)=3, so data_out={A,3}, fail=0.
- Erase d0+d1 (3'b011): fail_out=1, data_out={0,0}, valid_out 1 cycle after accept. Erase d0+p0 (3'b101): fail_out=1, data_out={0,3}.
- No erasures with parity corrupted to 4'hD: with CS_DEC_CHECK_EN, check_err_out=1 and data_out={A,3}. Without it, 1-cycle bypass and check_err_out=0.
- Backpressure: hold ready_out=0 for 3 cycles in OUT. Outputs stay stable, ready_in stays 0, and a valid_in pulse during that window is not accepted.
- Drive rst_n=0 for one edge during ACCUM: next cycle state=IDLE, valid_out=0, data_out=0, ready_in=1. A new codeword then decodes correctly.

Source files
------------

// File: rtl/cs_decoder.sv
// Erasure decoder for the systematic cyclic-shift + XOR MDS code from cs_encoder.
// Optional syndrome check on clean codewords is enabled by defining CS_DEC_CHECK_EN.
module cs_decoder #(
    parameter int unsigned M     = 2,
    parameter int unsigned K     = 3,
    parameter int unsigned WIDTH = 4,
    parameter logic [K-M-1:0][M-1:0][3:0] SHIFT_TABLE = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [K-1:0][WIDTH-1:0]   coded_in,
    input  logic [K-1:0]              erasure_in,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [M-1:0][WIDTH-1:0]   data_out,
    output logic                      fail_out,
    output logic                      check_err_out
);

    localparam int unsigned IDX_W = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, SOLVE, OUT} state_t;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input logic [3:0] s);
        int unsigned amt;
        logic [WIDTH-1:0] r;
        amt = int'(s) % WIDTH;
        r   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) r[(i + amt) % WIDTH] = v[i];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input logic [3:0] s);
        int unsigned amt;
        logic [WIDTH-1:0] r;
        amt = int'(s) % WIDTH;
        r   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) r[i] = v[(i + amt) % WIDTH];
        return r;
    endfunction

    state_t                  state_q, state_d;
    logic [M-1:0][WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0]        acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        e_q, e_d;
    logic                    e_valid_q, e_valid_d;
    logic [M-1:0][WIDTH-1:0] data_out_q, data_out_d;
    logic                    fail_q, fail_d;
    logic                    check_err_q, check_err_d;

    int unsigned             n_e;
    logic [IDX_W-1:0]        e_loc;
    logic                    go_accum;

    // Higher parity symbols never take part in decoding.
    logic unused_parity;
    assign unused_parity = ^(erasure_in >> (M + 1)) ^ ^(coded_in >> ((M + 1) * WIDTH));

    assign ready_in      = (state_q == IDLE) && rst_n;
    assign valid_out     = (state_q == OUT);
    assign data_out      = data_out_q;
    assign fail_out      = fail_q;
    assign check_err_out = check_err_q;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        e_d         = e_q;
        e_valid_d   = e_valid_q;
        data_out_d  = data_out_q;
        fail_d      = fail_q;
        check_err_d = check_err_q;
        n_e         = 0;
        e_loc       = '0;
        go_accum    = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in && ready_in) begin
                    for (int unsigned i = 0; i < M; i++) begin
                        data_d[i] = coded_in[i];
                        if (erasure_in[i]) begin
                            n_e   = n_e + 1;
                            e_loc = IDX_W'(i);
                        end
                    end
                    if (n_e == 1 && !erasure_in[M]) begin
                        go_accum = 1'b1;
                    end else if (n_e == 0) begin
`ifdef CS_DEC_CHECK_EN
                        go_accum = !erasure_in[M];
`else
                        go_accum = 1'b0;
`endif
                    end
                    if (go_accum) begin
                        acc_d     = coded_in[M];
                        idx_d     = '0;
                        e_d       = e_loc;
                        e_valid_d = (n_e == 1);
                        state_d   = ACCUM;
                    end else begin
                        for (int unsigned i = 0; i < M; i++)
                            data_out_d[i] = erasure_in[i] ? '0 : coded_in[i];
                        fail_d      = (n_e != 0);
                        check_err_d = 1'b0;
                        state_d     = OUT;
                    end
                end
            end
            ACCUM: begin
                if (!e_valid_q || idx_q != e_q)
                    acc_d = acc_q ^ rotl(data_q[idx_q], SHIFT_TABLE[0][idx_q]);
                if (idx_q == IDX_W'(M - 1)) state_d = SOLVE;
                else                        idx_d   = idx_q + 1'b1;
            end
            SOLVE: begin
                // Without an erased index this is the syndrome check: acc must be zero.
                data_out_d = data_q;
                if (e_valid_q) data_out_d[e_q] = rotr(acc_q, SHIFT_TABLE[0][e_q]);
                check_err_d = !e_valid_q && (acc_q != '0);
                fail_d      = 1'b0;
                state_d     = OUT;
            end
            OUT: begin
                if (ready_out) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            e_q         <= '0;
            e_valid_q   <= 1'b0;
            data_out_q  <= '0;
            fail_q      <= 1'b0;
            check_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            e_q         <= e_d;
            e_valid_q   <= e_valid_d;
            data_out_q  <= data_out_d;
            fail_q      <= fail_d;
            check_err_q <= check_err_d;
        end
    end

endmodule

// File: tb/tb_cs_decoder.sv
// Self-checking bench for cs_decoder (M=2, K=3, WIDTH=4, shifts {0,1}) against an arithmetic reference model.
module tb_cs_decoder;

    localparam int M = 2;
    localparam int K = 3;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic ready_out = 1'b0;
    logic ready_in, valid_out, fail_out, check_err_out;
    logic [K-1:0][W-1:0] coded_in = '0;
    logic [K-1:0]        erasure_in = '0;
    logic [M-1:0][W-1:0] data_out;

    int n_checks = 0;
    int n_pass   = 0;
    int sh [M] = '{0, 1};

    always #5 clk = ~clk;

    cs_decoder #(
        .M(M),
        .K(K),
        .WIDTH(W),
        .SHIFT_TABLE(8'h10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid_in(valid_in),
        .ready_in(ready_in),
        .coded_in(coded_in),
        .erasure_in(erasure_in),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .data_out(data_out),
        .fail_out(fail_out),
        .check_err_out(check_err_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int rl(input int v, input int s);
        int a = s % W;
        return ((v << a) | (v >> (W - a))) & 15;
    endfunction

    function automatic int rr(input int v, input int s);
        int a = s % W;
        return ((v >> a) | (v << (W - a))) & 15;
    endfunction

    task automatic run(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] p,
                       input logic [2:0] er, input int bp);
        int d [M];
        int ed [M];
        int ne, e, acc, exp_lat, exp_fail, exp_chk, lat, w;
        logic [7:0] exp_data;
        d[0] = d0; d[1] = d1;
        ne = 0; e = -1;
        for (int i = 0; i < M; i++) begin
            ed[i] = d[i];
            if (er[i]) begin ne++; e = i; end
        end
        exp_fail = 0; exp_chk = 0; exp_lat = 1;
        if (ne == 0) begin
`ifdef CS_DEC_CHECK_EN
            if (!er[M]) begin
                exp_lat = M + 2;
                acc = p;
                for (int i = 0; i < M; i++) acc ^= rl(d[i], sh[i]);
                exp_chk = (acc != 0);
            end
`endif
        end else if (ne == 1 && !er[M]) begin
            exp_lat = M + 2;
            acc = p;
            for (int i = 0; i < M; i++) if (i != e) acc ^= rl(d[i], sh[i]);
            ed[e] = rr(acc, sh[e]);
        end else begin
            exp_fail = 1;
            for (int i = 0; i < M; i++) if (er[i]) ed[i] = 0;
        end
        exp_data = {ed[1][3:0], ed[0][3:0]};

        @(negedge clk);
        w = 0;
        while (!ready_in && w < 20) begin @(negedge clk); w++; end
        check("ready_in_idle", 32'(ready_in), 32'd1);
        for (int i = 0; i < M; i++) coded_in[i] = er[i] ? 4'($urandom) : d[i][3:0];
        coded_in[M] = er[M] ? 4'($urandom) : p;
        erasure_in  = er;
        valid_in    = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        coded_in    = 12'($urandom);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!valid_out && lat < 20);
        check("latency", 32'(lat), 32'(exp_lat));
        check("data_out", 32'(data_out), 32'(exp_data));
        check("fail_out", 32'(fail_out), 32'(exp_fail));
        check("check_err", 32'(check_err_out), 32'(exp_chk));
        check("ready_in_busy", 32'(ready_in), 32'd0);

        for (int b = 0; b < bp; b++) begin
            valid_in   = 1'b1;
            coded_in   = 12'($urandom);
            erasure_in = 3'($urandom);
            @(negedge clk);
            check("bp_valid", 32'(valid_out), 32'd1);
            check("bp_ready_in", 32'(ready_in), 32'd0);
            check("bp_data", 32'(data_out), 32'(exp_data));
            check("bp_fail", 32'(fail_out), 32'(exp_fail));
            check("bp_chk", 32'(check_err_out), 32'(exp_chk));
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        @(posedge clk);
        #1 ready_out = 1'b0;
        check("valid_drop", 32'(valid_out), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_fail", 32'(fail_out), 32'd0);
        check("rst_chk", 32'(check_err_out), 32'd0);
        check("rst_ready_low", 32'(ready_in), 32'd0);
        rst_n = 1'b1;
        #1 check("rst_ready_high", 32'(ready_in), 32'd1);

        run(4'hA, 4'h3, 4'hC, 3'b001, 0);
        run(4'hA, 4'h3, 4'hC, 3'b010, 0);
        run(4'hA, 4'h3, 4'hC, 3'b011, 0);
        run(4'hA, 4'h3, 4'hC, 3'b101, 0);
        run(4'hA, 4'h3, 4'hD, 3'b000, 3);

        // Reset mid-ACCUM drops the codeword.
        @(negedge clk);
        coded_in   = {4'hC, 4'h3, 4'h5};
        erasure_in = 3'b001;
        valid_in   = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_valid", 32'(valid_out), 32'd0);
        check("midrst_data", 32'(data_out), 32'd0);
        check("midrst_fail", 32'(fail_out), 32'd0);
        check("midrst_ready", 32'(ready_in), 32'd1);
        run(4'hA, 4'h3, 4'hC, 3'b001, 0);

        for (int t = 0; t < 40; t++) begin
            logic [3:0] r0, r1, rp;
            r0 = 4'($urandom);
            r1 = 4'($urandom);
            rp = 4'(rl(r0, sh[0]) ^ rl(r1, sh[1]));
            if ($urandom_range(0, 3) == 0) rp = rp ^ 4'($urandom_range(1, 15));
            run(r0, r1, rp, 3'($urandom), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
